dram_nbank: RTL and testbench
=============================

# dram_nbank

Parametrised successor to the fixed 4x8 data RAM: a single-port data memory made of `NBANKS` independently byte-enabled banks, each `BANK_W` bits wide. It adds a valid/ready request channel and a credit-controlled read-response channel that handles back-pressure. It has an optional output register and a post-reset zero-clear sequencer. It sits between the pqr5 load/store unit and the subsystem bus, in place of the fixed-width data RAM.

## Interface
Parameters:
- `DEPTH`, 1024: words per bank; implemented depth `DEPTH_2N = 2**$clog2(DEPTH)`.
- `NBANKS`, 4: number of lanes (banks); must be ≥1.
- `BANK_W`, 8: bits per lane.
- `OUT_REG`, 0: 1 adds one output pipeline stage, so `READ_LAT = 1 + OUT_REG`.
- `INIT_CLR`, 1: 1 zero-fills every word after reset before accepting requests.
- Derived: `DATA_W = NBANKS*BANK_W`, `ADDR_W = $clog2(DEPTH)`, `RSP_DEPTH = READ_LAT + 1`.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  1  request valid.
- `o_req_ready`  out  1  request accepted when valid & ready.
- `i_req_wen`  in  1  1 = write, 0 = read.
- `i_req_ben`  in  NBANKS  lane enables.
- `i_req_addr`  in  ADDR_W  word address.
- `i_req_wdata`  in  DATA_W  write data; lane k = bits [k*BANK_W +: BANK_W].
- `o_rsp_valid`  out  1  read response valid.
- `i_rsp_ready`  in  1  response consumed when valid & ready.
- `o_rsp_rdata`  out  DATA_W  read data.
- `o_busy`  out  1  init-clear in progress.

## Operation
- FSM states are `ST_INIT` and `ST_RUN`. Reset enters `ST_INIT` if `INIT_CLR=1`, otherwise `ST_RUN`.
- In `ST_INIT`, a clear counter runs 0..`DEPTH_2N-1` and writes zero to all lanes, one word per cycle. `o_req_ready=0` and `o_busy=1`. After address `DEPTH_2N-1` is written, the FSM goes to `ST_RUN`, which is terminal until reset.
- **Write:** only lanes with `i_req_ben[k]=1` are updated; other lanes keep their value. Writes produce no response and do not use credits.
- **Read:** all lanes are read. Lanes with `ben[k]=0` return zero in the response. The mask is carried alongside the read pipeline.
- **Response path:** a `RSP_DEPTH`-entry FIFO with first-word-fall-through. A credit counter is initialised to `RSP_DEPTH`.
  - An accepted read decrements the counter; a response pop increments it. If both happen in the same cycle, the count is unchanged.
- `o_req_ready = (state==ST_RUN) && (i_req_wen || credits!=0)`. Ready may depend combinationally on `i_req_wen`.
- Responses return in request order. None are dropped or duplicated.
- Read-after-write to the same address in the following cycle returns the new data.
- A request with `ben=0` is accepted. As a write it is a no-op; as a read it returns all-zero data.
- Reset mid-operation: in-flight reads and FIFO contents are discarded and credits restore to `RSP_DEPTH`. If `INIT_CLR=1`, the clear restarts at address 0. Memory content is otherwise not guaranteed after reset.

## Timing
- Reset values: `o_req_ready=0`, `o_rsp_valid=0`, `o_rsp_rdata=0`, `o_busy=INIT_CLR`.
- Init phase: `o_busy` is high for exactly `DEPTH_2N` cycles after reset deassertion. `o_req_ready` may rise in the next cycle.
- Read latency: a read accepted at edge T with the FIFO empty gives `o_rsp_valid=1` from edge T+`READ_LAT`.
- Throughput: one request per cycle, sustained, while `i_rsp_ready=1`.
- Back-pressure: with `i_rsp_ready=0`, exactly `RSP_DEPTH` reads are accepted before `o_req_ready` drops for reads. Writes continue to be accepted.
- `o_rsp_valid` and `o_rsp_rdata` stay stable while valid & !ready.

## Structure
- `pqr5_subsystem_pkg` holds:
  - the `dram_nbank_state_t` enum (`ST_INIT`, `ST_RUN`);
  - the default bank-width constant.
- Sub-module: the existing `dram` single-bank RAM, instantiated `NBANKS` times in a generate loop. Its `i_en` is the per-lane enable during run, or all ones during init; its `i_wen` is the write enable.
- Response FIFO and credit counter are inline. Keep the `MEM_DBG` per-bank array exposure and the `DMEM_DUMP` hook, generalised to `NBANKS` lanes.

## Test plan
- Use `NBANKS=4`, `BANK_W=8`, `DEPTH=16`, `INIT_CLR=1`. Release reset, then:
  - `o_busy` is high for 16 cycles.
  - Reading address 5 returns `0x00000000` at T+1.
- Write 0xA1B2C3D4 to address 3 with `ben=4'b1111`, then write 0xFFFFFFFF with `ben=4'b0101`. Reading with `ben=4'b1111` returns 0xA1FFC3FF. Reading with `ben=4'b0011` returns 0x0000C3FF.
- With `OUT_REG=1`, issue back-to-back reads of addresses 0..7 while `i_rsp_ready=1`. Expect 8 in-order responses starting at T+2 with no bubbles.
- Hold `i_rsp_ready=0` and stream reads. Expect:
  - exactly 3 accepted when `OUT_REG=1`;
  - `o_req_ready` then low for reads but high for writes;
  - after releasing `i_rsp_ready`, all 3 responses in order and unchanged while stalled.
- Assert `rst` for 1 cycle while 2 reads are in flight. Expect:
  - `o_rsp_valid=0` immediately;
  - no stale response afterwards;
  - the clear restarts and credits are restored.
- With `NBANKS=2`, `BANK_W=16`, `INIT_CLR=0`: `o_req_ready=1` in the first cycle after reset. A write of 0xBEEF to lane 1 at address 7 reads back as 0xBEEF0000 when both lanes are enabled.

Source files
------------

// File: rtl/dram_nbank_pkg.sv
// Shared types and constants for the pqr5 data-memory subsystem.
package pqr5_subsystem_pkg;
  typedef enum logic {ST_INIT, ST_RUN} dram_nbank_state_t;
  localparam int DRAM_BANK_W = 8;
endpackage

// File: rtl/dram.sv
// Single-bank synchronous RAM: write or registered read when enabled.
module dram #(
  parameter  int DEPTH = 1024,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_wen,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_wen) r_mem[i_addr] <= i_wdata;
      else       r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dram_nbank.sv
// Banked byte-enabled data RAM with valid/ready requests, credit-limited
// read responses through a small FWFT FIFO, and post-reset zero clear.
module dram_nbank import pqr5_subsystem_pkg::*; #(
  parameter  int DEPTH     = 1024,
  parameter  int NBANKS    = 4,
  parameter  int BANK_W    = DRAM_BANK_W,
  parameter  int OUT_REG   = 0,
  parameter  int INIT_CLR  = 1,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int DEPTH_2N  = 2**ADDR_W,
  localparam int DATA_W    = NBANKS*BANK_W,
  localparam int READ_LAT  = 1 + OUT_REG,
  localparam int RSP_DEPTH = READ_LAT + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [NBANKS-1:0] i_req_ben,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_busy
);
  localparam int CW = $clog2(RSP_DEPTH+1);
  localparam int PW = $clog2(RSP_DEPTH);

  dram_nbank_state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [CW-1:0]     r_credits, r_cnt;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [DATA_W-1:0] r_fifo [RSP_DEPTH];
  logic [READ_LAT:1] r_vld_pipe;
  logic [NBANKS-1:0] r_mask, w_en;
  logic              w_run, w_acc, w_rd_acc, w_pop, w_push, w_fifo_pop, w_fifo_empty;
  logic              w_bank_wen, w_pipe_vld;
  logic [ADDR_W-1:0] w_bank_addr;
  logic [DATA_W-1:0] w_bank_wdata, w_rdata_raw, w_s1_data, w_pipe_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= (INIT_CLR != 0) ? ST_INIT : ST_RUN;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      if (r_state == ST_INIT) r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_clr_addr == '1) w_state_nxt = ST_RUN;
  end

  assign w_run       = (r_state == ST_RUN);
  assign o_busy      = (r_state == ST_INIT);
  assign o_req_ready = w_run && (i_req_wen || r_credits != '0);
  assign w_acc       = i_req_valid && o_req_ready;
  assign w_rd_acc    = w_acc && !i_req_wen;

  // During init every lane writes zero at the clear address.
  assign w_en         = w_run ? (i_req_ben & {NBANKS{w_acc}}) : '1;
  assign w_bank_wen   = w_run ? i_req_wen   : 1'b1;
  assign w_bank_addr  = w_run ? i_req_addr  : r_clr_addr;
  assign w_bank_wdata = w_run ? i_req_wdata : '0;

  for (genvar k = 0; k < NBANKS; k++) begin : g_bank
    dram #(.DEPTH(DEPTH_2N), .W(BANK_W)) u_bank (
      .clk     (clk),
      .i_en    (w_en[k]),
      .i_wen   (w_bank_wen),
      .i_addr  (w_bank_addr),
      .i_wdata (w_bank_wdata[k*BANK_W +: BANK_W]),
      .o_rdata (w_rdata_raw[k*BANK_W +: BANK_W])
    );
    assign w_s1_data[k*BANK_W +: BANK_W] = r_mask[k] ? w_rdata_raw[k*BANK_W +: BANK_W] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_mask     <= '0;
    end else begin
      r_vld_pipe[1] <= w_rd_acc;
      for (int i = 2; i <= READ_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (w_rd_acc) r_mask <= i_req_ben;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_data_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_data_q <= '0;
      else if (r_vld_pipe[1]) r_data_q <= w_s1_data;
    end
    assign w_pipe_data = r_data_q;
  end else begin : g_noreg
    assign w_pipe_data = w_s1_data;
  end

  // Pipeline output bypasses an empty FIFO; anything not taken is parked.
  assign w_pipe_vld   = r_vld_pipe[READ_LAT];
  assign w_fifo_empty = (r_cnt == '0);
  assign o_rsp_valid  = !w_fifo_empty || w_pipe_vld;
  assign o_rsp_rdata  = !w_fifo_empty ? r_fifo[r_rptr] : (w_pipe_vld ? w_pipe_data : '0);
  assign w_pop        = o_rsp_valid && i_rsp_ready;
  assign w_fifo_pop   = w_pop && !w_fifo_empty;
  assign w_push       = w_pipe_vld && !(w_fifo_empty && i_rsp_ready);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_pipe_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CW'(RSP_DEPTH);
      r_cnt     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      case ({w_rd_acc, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: ;
      endcase
      case ({w_push, w_fifo_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (w_push)     r_wptr <= (r_wptr == PW'(RSP_DEPTH-1)) ? '0 : r_wptr + 1'b1;
      if (w_fifo_pop) r_rptr <= (r_rptr == PW'(RSP_DEPTH-1)) ? '0 : r_rptr + 1'b1;
    end
  end

`ifdef MEM_DBG
  logic [BANK_W-1:0] w_mem_dbg [NBANKS][DEPTH_2N];
  for (genvar k = 0; k < NBANKS; k++) begin : g_dbg
    assign w_mem_dbg[k] = g_bank[k].u_bank.r_mem;
  end
`endif
`ifdef DMEM_DUMP
  logic [BANK_W-1:0] w_dump_mem [NBANKS][DEPTH_2N];
  for (genvar k = 0; k < NBANKS; k++) begin : g_dump
    assign w_dump_mem[k] = g_bank[k].u_bank.r_mem;
  end
  function automatic logic [DATA_W-1:0] dmem_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < NBANKS; k++) w[k*BANK_W +: BANK_W] = w_dump_mem[k][a];
    return w;
  endfunction
`endif
endmodule

// File: tb/tb_dram_nbank.sv
// Directed bench for dram_nbank: three configurations share clock, reset and request fields.
module tb_dram_nbank;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic        wen = 1'b0, rsp_rdy = 1'b1;
  logic [3:0]  ben = '0, addr = '0;
  logic [31:0] wdata = '0;
  logic        rdy0, rdy1, rdy2, rv0, rv1, rv2, busy0, busy1, busy2;
  logic [31:0] rd0, rd1, rd2;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  dram_nbank #(.DEPTH(16), .NBANKS(4), .BANK_W(8), .OUT_REG(0), .INIT_CLR(1)) u0 (
    .clk(clk), .rst(rst), .i_req_valid(v0), .o_req_ready(rdy0), .i_req_wen(wen),
    .i_req_ben(ben), .i_req_addr(addr), .i_req_wdata(wdata), .o_rsp_valid(rv0),
    .i_rsp_ready(rsp_rdy), .o_rsp_rdata(rd0), .o_busy(busy0));
  dram_nbank #(.DEPTH(16), .NBANKS(4), .BANK_W(8), .OUT_REG(1), .INIT_CLR(1)) u1 (
    .clk(clk), .rst(rst), .i_req_valid(v1), .o_req_ready(rdy1), .i_req_wen(wen),
    .i_req_ben(ben), .i_req_addr(addr), .i_req_wdata(wdata), .o_rsp_valid(rv1),
    .i_rsp_ready(rsp_rdy), .o_rsp_rdata(rd1), .o_busy(busy1));
  dram_nbank #(.DEPTH(16), .NBANKS(2), .BANK_W(16), .OUT_REG(0), .INIT_CLR(0)) u2 (
    .clk(clk), .rst(rst), .i_req_valid(v2), .o_req_ready(rdy2), .i_req_wen(wen),
    .i_req_ben(ben[1:0]), .i_req_addr(addr), .i_req_wdata(wdata), .o_rsp_valid(rv2),
    .i_rsp_ready(rsp_rdy), .o_rsp_rdata(rd2), .o_busy(busy2));

  typedef struct {
    logic        w;
    logic [3:0]  b;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
    wen = w; ben = b; addr = a; wdata = d;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h10203040 + 32'(i) * 32'h01010101;
  endfunction

  // Counts cycles with o_busy high on u0/u1 starting at the release sample.
  task automatic wait_init(input string name);
    int n0, n1;
    logic stale;
    n0 = 0; n1 = 0; stale = 1'b0;
    while ((busy0 || busy1) && n0 < 40) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (rv0 || rv1) stale = 1'b1;
      @(negedge clk); #1;
    end
    chk({name, " busy0 cycles"}, 32'(n0), 32'd16);
    chk({name, " busy1 cycles"}, 32'(n1), 32'd16);
    chk({name, " no rsp during init"}, {31'd0, stale}, 32'd0);
    chk({name, " rdy0 after init"}, {31'd0, rdy0}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[14];
    int   acc;
    logic [31:0] held;
    vt[0]  = '{1'b0, 4'hF, 4'd5,  32'h0,        32'h00000000};
    vt[1]  = '{1'b1, 4'hF, 4'd3,  32'hA1B2C3D4, 32'h0};
    vt[2]  = '{1'b1, 4'h5, 4'd3,  32'hFFFFFFFF, 32'h0};
    vt[3]  = '{1'b0, 4'hF, 4'd3,  32'h0,        32'hA1FFC3FF};
    vt[4]  = '{1'b0, 4'h3, 4'd3,  32'h0,        32'h0000C3FF};
    vt[5]  = '{1'b0, 4'h0, 4'd3,  32'h0,        32'h00000000};
    vt[6]  = '{1'b1, 4'h0, 4'd3,  32'hFFFFFFFF, 32'h0};
    vt[7]  = '{1'b0, 4'hF, 4'd3,  32'h0,        32'hA1FFC3FF};
    vt[8]  = '{1'b1, 4'h8, 4'd9,  32'h12345678, 32'h0};
    vt[9]  = '{1'b0, 4'hF, 4'd9,  32'h0,        32'h12000000};
    vt[10] = '{1'b1, 4'hF, 4'd15, 32'hCAFEF00D, 32'h0};
    vt[11] = '{1'b0, 4'hF, 4'd15, 32'h0,        32'hCAFEF00D};
    vt[12] = '{1'b0, 4'hC, 4'd15, 32'h0,        32'hCAFE0000};
    vt[13] = '{1'b0, 4'hF, 4'd14, 32'h0,        32'h00000000};

    // Reset values
    @(negedge clk); @(negedge clk); #1;
    chk("rst rdy0", {31'd0, rdy0}, 32'd0);
    chk("rst rv0", {31'd0, rv0}, 32'd0);
    chk("rst rd0", rd0, 32'd0);
    chk("rst busy0", {31'd0, busy0}, 32'd1);
    chk("rst busy2", {31'd0, busy2}, 32'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("u2 ready first cycle", {31'd0, rdy2}, 32'd1);
    wait_init("init");

    // Table-driven single-cycle traffic on u0
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      v0 = 1'b1;
      drive(vt[i].w, vt[i].b, vt[i].a, vt[i].d);
      #1 chk($sformatf("vec%0d rdy", i), {31'd0, rdy0}, 32'd1);
      @(negedge clk);
      if (!vt[i].w) begin
        chk($sformatf("vec%0d rv", i), {31'd0, rv0}, 32'd1);
        chk($sformatf("vec%0d rdata", i), rd0, vt[i].exp);
      end else begin
        chk($sformatf("vec%0d rv", i), {31'd0, rv0}, 32'd0);
      end
    end
    v0 = 1'b0;

    // u1: fill 0..7 then back-to-back reads, expect no bubbles
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; drive(1'b1, 4'hF, 4'(i), pat(i));
      @(negedge clk);
    end
    for (int c = 0; c < 11; c++) begin
      v1 = (c < 8); drive(1'b0, 4'hF, 4'(c), 32'h0);
      #1 if (c < 8) chk($sformatf("b2b rdy c%0d", c), {31'd0, rdy1}, 32'd1);
      @(negedge clk);
      chk($sformatf("b2b rv c%0d", c), {31'd0, rv1}, {31'd0, (c >= 1 && c <= 8)});
      if (c >= 1 && c <= 8) chk($sformatf("b2b rdata c%0d", c), rd1, pat(c - 1));
    end

    // u1: back-pressure
    rsp_rdy = 1'b0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      v1 = 1'b1; drive(1'b0, 4'hF, 4'(acc), 32'h0);
      #1 if (rdy1) acc++;
      @(negedge clk);
    end
    chk("bp accepted", 32'(acc), 32'd3);
    held = rd1;
    chk("bp rv held", {31'd0, rv1}, 32'd1);
    chk("bp head", held, pat(0));
    v1 = 1'b0;
    #1 chk("bp read rdy low", {31'd0, rdy1}, 32'd0);
    wen = 1'b1;
    #1 chk("bp write rdy high", {31'd0, rdy1}, 32'd1);
    wen = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("bp stable data", rd1, pat(0));
    rsp_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("drain rv%0d", j), {31'd0, rv1}, 32'd1);
      chk($sformatf("drain rdata%0d", j), rd1, pat(j));
      @(negedge clk);
    end
    chk("drain empty", {31'd0, rv1}, 32'd0);

    // u1: reset with two reads in flight
    v1 = 1'b1; drive(1'b0, 4'hF, 4'd1, 32'h0);
    @(negedge clk);
    drive(1'b0, 4'hF, 4'd2, 32'h0);
    @(negedge clk);
    v1 = 1'b0; rst = 1'b1;
    #1;
    chk("mid rst rv1", {31'd0, rv1}, 32'd0);
    chk("mid rst rd1", rd1, 32'd0);
    chk("mid rst busy1", {31'd0, busy1}, 32'd1);
    chk("mid rst rdy1", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("u2 ready after rst", {31'd0, rdy2}, 32'd1);
    wait_init("reinit");
    @(negedge clk);
    v1 = 1'b1; drive(1'b0, 4'hF, 4'd1, 32'h0);
    @(negedge clk);
    v1 = 1'b0;
    chk("post rst no rsp yet", {31'd0, rv1}, 32'd0);
    @(negedge clk);
    chk("post rst rv", {31'd0, rv1}, 32'd1);
    chk("post rst cleared", rd1, 32'd0);
    @(negedge clk);
    chk("post rst single rsp", {31'd0, rv1}, 32'd0);
    rsp_rdy = 1'b0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      v1 = 1'b1; drive(1'b0, 4'hF, 4'(acc), 32'h0);
      #1 if (rdy1) acc++;
      @(negedge clk);
    end
    v1 = 1'b0;
    chk("credits restored", 32'(acc), 32'd3);
    rsp_rdy = 1'b1;
    for (int j = 0; j < 8 && rv1; j++) @(negedge clk);
    chk("credits drained", {31'd0, rv1}, 32'd0);

    // u2: two 16-bit lanes, no init clear
    v2 = 1'b1; drive(1'b1, 4'h3, 4'd7, 32'h00000000);
    @(negedge clk);
    drive(1'b1, 4'h2, 4'd7, 32'hBEEF1234);
    @(negedge clk);
    drive(1'b0, 4'h3, 4'd7, 32'h0);
    @(negedge clk);
    chk("u2 rv", {31'd0, rv2}, 32'd1);
    chk("u2 lane1", rd2, 32'hBEEF0000);
    drive(1'b0, 4'h2, 4'd7, 32'h0);
    @(negedge clk);
    chk("u2 lane1 masked", rd2, 32'hBEEF0000);
    drive(1'b0, 4'h1, 4'd7, 32'h0);
    @(negedge clk);
    chk("u2 lane0 only", rd2, 32'h00000000);
    v2 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
